trap_ctrl: RTL and testbench

Machine-mode trap responder for the 5-stage RV32 core. It consumes the ecall/mret flags raised by the decode stage and the level timer interrupt from the hwtimer. It sequences the CSR side effects (mepc, mcause, mstatus) over the CSR regfile's single write port, holds the pipeline while doing so, and then redirects the PC to mtvec or mepc. It sits beside `ctrl`: its hold request and jump outputs feed the same PC/flush logic as branch redirects.

---
 rtl/trap_ctrl_pkg.sv | 43 ++++
 rtl/trap_ctrl.sv | 124 ++++++++++++
 tb/tb_trap_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap responder: CSR addresses,
// mstatus bit positions, FSM state encodings and mstatus update helpers.
package trap_ctrl_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // mstatus / mie bit indices
    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MIE_MTIE     = 7;

    // FSM state encodings
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MEPC    = 3'd1;
    localparam logic [2:0] S_MCAUSE  = 3'd2;
    localparam logic [2:0] S_MSTATUS = 3'd3;
    localparam logic [2:0] S_MRET    = 3'd4;
    localparam logic [2:0] S_JUMP    = 3'd5;

    // Trap entry: MPIE <= MIE, MIE <= 0, everything else unchanged
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
        logic [31:0] r;
        r               = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    // Trap return: MIE <= MPIE, MPIE <= 1
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
        logic [31:0] r;
        r               = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap responder: accepts ecall / mret / timer interrupt from
// the ID stage, sequences mepc/mcause/mstatus writes over the CSR write port
// while holding the pipeline, then redirects the PC to mtvec or mepc.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] ECALL_CAUSE = 32'd11,
    parameter logic [31:0] TIMER_CAUSE = 32'h8000_0007
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] exception_i,
    input  logic [31:0] inst_addr_i,
    input  logic        inst_valid_i,
    input  logic        irq_timer_i,
    input  logic [31:0] csr_mstatus_i,
    input  logic [31:0] csr_mie_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        hold_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o
);

    logic [2:0]  state_q;
    logic [31:0] pc_q;
    logic [31:0] cause_q;
    logic        mret_q;

    logic ecall_req;
    logic mret_req;
    logic timer_req;
    logic any_req;

    // Bits of the CSR/exception inputs this block never looks at
    logic unused_bits;
    assign unused_bits = ^{exception_i[31:2], csr_mie_i[31:8], csr_mie_i[6:0],
                           csr_mtvec_i[1:0]};

    // Request decode with ecall > mret > timer priority
    always_comb begin
        ecall_req = inst_valid_i & exception_i[1];
        mret_req  = inst_valid_i & exception_i[0] & ~exception_i[1];
        timer_req = inst_valid_i & irq_timer_i & csr_mstatus_i[MSTATUS_MIE]
                  & csr_mie_i[MIE_MTIE] & ~exception_i[1] & ~exception_i[0];
        any_req   = ecall_req | mret_req | timer_req;
    end

    // State register and trap context latches
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            mret_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        pc_q    <= inst_addr_i;
                        cause_q <= ecall_req ? ECALL_CAUSE : TIMER_CAUSE;
                        mret_q  <= mret_req & ~ecall_req;
                        state_q <= (ecall_req | timer_req) ? S_MEPC : S_MRET;
                    end
                end
                S_MEPC:    state_q <= S_MCAUSE;
                S_MCAUSE:  state_q <= S_MSTATUS;
                S_MSTATUS: state_q <= S_JUMP;
                S_MRET:    state_q <= S_JUMP;
                S_JUMP:    state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs: CSR write port, hold and redirect; forced low while in reset
    always_comb begin
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        hold_o      = 1'b0;
        jump_flag_o = 1'b0;
        jump_addr_o = '0;
        if (!rst_i) begin
            case (state_q)
                S_IDLE: hold_o = any_req;
                S_MEPC: begin
                    hold_o      = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MEPC;
                    csr_wdata_o = pc_q;
                end
                S_MCAUSE: begin
                    hold_o      = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MCAUSE;
                    csr_wdata_o = cause_q;
                end
                S_MSTATUS: begin
                    hold_o      = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MSTATUS;
                    csr_wdata_o = mstatus_on_trap(csr_mstatus_i);
                end
                S_MRET: begin
                    hold_o      = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MSTATUS;
                    csr_wdata_o = mstatus_on_mret(csr_mstatus_i);
                end
                S_JUMP: begin
                    hold_o      = 1'b1;
                    jump_flag_o = 1'b1;
                    jump_addr_o = mret_q ? csr_mepc_i : {csr_mtvec_i[31:2], 2'b00};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed per-cycle vector bench for trap_ctrl, plus a hand-written
// reset-abort sequence.
module tb_trap_ctrl;

    logic        clk;
    logic        rst_i;
    logic [31:0] exception_i;
    logic [31:0] inst_addr_i;
    logic        inst_valid_i;
    logic        irq_timer_i;
    logic [31:0] csr_mstatus_i;
    logic [31:0] csr_mie_i;
    logic [31:0] csr_mtvec_i;
    logic [31:0] csr_mepc_i;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        hold_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;

    int tests_run;
    int tests_failed;

    trap_ctrl #(
        .ECALL_CAUSE(32'd11),
        .TIMER_CAUSE(32'h8000_0007)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .exception_i  (exception_i),
        .inst_addr_i  (inst_addr_i),
        .inst_valid_i (inst_valid_i),
        .irq_timer_i  (irq_timer_i),
        .csr_mstatus_i(csr_mstatus_i),
        .csr_mie_i    (csr_mie_i),
        .csr_mtvec_i  (csr_mtvec_i),
        .csr_mepc_i   (csr_mepc_i),
        .csr_we_o     (csr_we_o),
        .csr_waddr_o  (csr_waddr_o),
        .csr_wdata_o  (csr_wdata_o),
        .hold_o       (hold_o),
        .jump_flag_o  (jump_flag_o),
        .jump_addr_o  (jump_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] exc;
        logic [31:0] pc;
        logic        valid;
        logic        irq;
        logic [31:0] mstatus;
        logic [31:0] mie;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        hold;
        logic        jf;
        logic [31:0] jaddr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic [31:0] exc, input logic [31:0] pc,
        input logic valid, input logic irq, input logic [31:0] ms,
        input logic [31:0] mie, input logic [31:0] mtvec, input logic [31:0] mepc,
        input logic we, input logic [11:0] wa, input logic [31:0] wd,
        input logic hold, input logic jf, input logic [31:0] ja);
        vec_t v;
        v.rst = rst; v.exc = exc; v.pc = pc; v.valid = valid; v.irq = irq;
        v.mstatus = ms; v.mie = mie; v.mtvec = mtvec; v.mepc = mepc;
        v.we = we; v.waddr = wa; v.wdata = wd; v.hold = hold; v.jf = jf; v.jaddr = ja;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst_i         = v.rst;
        exception_i   = v.exc;
        inst_addr_i   = v.pc;
        inst_valid_i  = v.valid;
        irq_timer_i   = v.irq;
        csr_mstatus_i = v.mstatus;
        csr_mie_i     = v.mie;
        csr_mtvec_i   = v.mtvec;
        csr_mepc_i    = v.mepc;
    endtask

    task automatic check(input string name, input vec_t v);
        logic [78:0] act;
        logic [78:0] exp;
        act = {csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, jump_flag_o, jump_addr_o};
        exp = {v.we, v.waddr, v.wdata, v.hold, v.jf, v.jaddr};
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got we=%b wa=%h wd=%h hold=%b jf=%b ja=%h, want we=%b wa=%h wd=%h hold=%b jf=%b ja=%h",
                     name, csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, jump_flag_o, jump_addr_o,
                     v.we, v.waddr, v.wdata, v.hold, v.jf, v.jaddr);
        end
    endtask

    initial begin
        vec_t v;
        tests_run    = 0;
        tests_failed = 0;

        //        rst exc    pc       vld irq ms     mie    mtvec  mepc     we wa      wd            hold jf ja
        // reset with an ecall presented: outputs all zero
        tbl.push_back(mk(1, 32'h2, 32'h100, 1, 0, 32'h8, 32'h80, 32'h200, 0,  0, 12'h0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0, 32'h0,   0, 0, 32'h8, 32'h80, 32'h200, 0,  0, 12'h0, 32'h0,        0, 0, 32'h0));
        // only unused exception bit: ignored
        tbl.push_back(mk(0, 32'h4, 32'h50,  1, 0, 32'h8, 32'h80, 32'h200, 0,  0, 12'h0, 32'h0,        0, 0, 32'h0));
        // ecall at 0x100
        tbl.push_back(mk(0, 32'h2, 32'h100, 1, 0, 32'h8, 32'h80, 32'h200, 0,  0, 12'h0, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h2, 32'h100, 1, 0, 32'h8, 32'h80, 32'h200, 0,  1, 12'h341, 32'h100,    1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h2, 32'h100, 1, 0, 32'h8, 32'h80, 32'h200, 0,  1, 12'h342, 32'd11,     1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h2, 32'h100, 1, 0, 32'h8, 32'h80, 32'h200, 0,  1, 12'h300, 32'h80,     1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h2, 32'h100, 1, 0, 32'h80, 32'h80, 32'h200, 0, 0, 12'h0, 32'h0,        1, 1, 32'h200));
        tbl.push_back(mk(0, 32'h0, 32'h0,   0, 0, 32'h80, 32'h80, 32'h200, 0, 0, 12'h0, 32'h0,        0, 0, 32'h0));
        // mret with mepc 0x104
        tbl.push_back(mk(0, 32'h1, 32'h220, 1, 0, 32'h80, 32'h80, 32'h200, 32'h104, 0, 12'h0, 32'h0,    1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h1, 32'h220, 1, 0, 32'h80, 32'h80, 32'h200, 32'h104, 1, 12'h300, 32'h88, 1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h1, 32'h220, 1, 0, 32'h88, 32'h80, 32'h200, 32'h104, 0, 12'h0, 32'h0,    1, 1, 32'h104));
        tbl.push_back(mk(0, 32'h0, 32'h0,   0, 0, 32'h88, 32'h80, 32'h200, 32'h104, 0, 12'h0, 32'h0,    0, 0, 32'h0));
        // timer at 0x40, mtvec low bits set
        tbl.push_back(mk(0, 32'h0, 32'h40,  1, 1, 32'h88, 32'h80, 32'h203, 0, 0, 12'h0, 32'h0,          1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0, 32'h40,  1, 1, 32'h88, 32'h80, 32'h203, 0, 1, 12'h341, 32'h40,       1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0, 32'h40,  1, 1, 32'h88, 32'h80, 32'h203, 0, 1, 12'h342, 32'h8000_0007, 1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0, 32'h40,  1, 1, 32'h88, 32'h80, 32'h203, 0, 1, 12'h300, 32'h80,       1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0, 32'h40,  1, 1, 32'h80, 32'h80, 32'h203, 0, 0, 12'h0, 32'h0,          1, 1, 32'h200));
        tbl.push_back(mk(0, 32'h0, 32'h0,   0, 1, 32'h80, 32'h80, 32'h203, 0, 0, 12'h0, 32'h0,          0, 0, 32'h0));
        // masked: MIE=0, then MTIE=0
        tbl.push_back(mk(0, 32'h0, 32'h200, 1, 1, 32'h80, 32'h80, 32'h200, 0, 0, 12'h0, 32'h0,          0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0, 32'h200, 1, 1, 32'h88, 32'h00, 32'h200, 0, 0, 12'h0, 32'h0,          0, 0, 32'h0));
        // ecall and timer together at 0x60
        tbl.push_back(mk(0, 32'h2, 32'h60,  1, 1, 32'h88, 32'h80, 32'h200, 0, 0, 12'h0, 32'h0,          1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h2, 32'h60,  1, 1, 32'h88, 32'h80, 32'h200, 0, 1, 12'h341, 32'h60,       1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h2, 32'h60,  1, 1, 32'h88, 32'h80, 32'h200, 0, 1, 12'h342, 32'd11,       1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h2, 32'h60,  1, 1, 32'h88, 32'h80, 32'h200, 0, 1, 12'h300, 32'h80,       1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h2, 32'h60,  1, 1, 32'h80, 32'h80, 32'h200, 0, 0, 12'h0, 32'h0,          1, 1, 32'h200));
        tbl.push_back(mk(0, 32'h0, 32'h0,   0, 1, 32'h80, 32'h80, 32'h200, 0, 0, 12'h0, 32'h0,          0, 0, 32'h0));
        // handler runs with timer pending but masked
        tbl.push_back(mk(0, 32'h0, 32'h200, 1, 1, 32'h80, 32'h80, 32'h200, 0, 0, 12'h0, 32'h0,          0, 0, 32'h0));
        // mret at 0x204 (mret beats pending timer), mepc = 0x64
        tbl.push_back(mk(0, 32'h1, 32'h204, 1, 1, 32'h80, 32'h80, 32'h200, 32'h64, 0, 12'h0, 32'h0,     1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h1, 32'h204, 1, 1, 32'h80, 32'h80, 32'h200, 32'h64, 1, 12'h300, 32'h88,  1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h1, 32'h204, 1, 1, 32'h88, 32'h80, 32'h200, 32'h64, 0, 12'h0, 32'h0,     1, 1, 32'h64));
        tbl.push_back(mk(0, 32'h0, 32'h0,   0, 1, 32'h88, 32'h80, 32'h200, 32'h64, 0, 12'h0, 32'h0,     0, 0, 32'h0));
        // first valid instruction after return (0x64) takes the timer
        tbl.push_back(mk(0, 32'h0, 32'h64,  1, 1, 32'h88, 32'h80, 32'h200, 0, 0, 12'h0, 32'h0,          1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0, 32'h64,  1, 1, 32'h88, 32'h80, 32'h200, 0, 1, 12'h341, 32'h64,       1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0, 32'h64,  1, 1, 32'h88, 32'h80, 32'h200, 0, 1, 12'h342, 32'h8000_0007, 1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0, 32'h64,  1, 1, 32'h88, 32'h80, 32'h200, 0, 1, 12'h300, 32'h80,       1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0, 32'h64,  1, 1, 32'h80, 32'h80, 32'h200, 0, 0, 12'h0, 32'h0,          1, 1, 32'h200));
        tbl.push_back(mk(0, 32'h0, 32'h0,   0, 1, 32'h80, 32'h80, 32'h200, 0, 0, 12'h0, 32'h0,          0, 0, 32'h0));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            #1;
            check($sformatf("vec%0d", i), tbl[i]);
            @(negedge clk);
        end

        // Reset asserted at T+2 of an ecall trap: sequence abandoned
        v = mk(0, 32'h2, 32'h100, 1, 0, 32'h8, 32'h80, 32'h200, 0, 0, 12'h0, 32'h0, 1, 0, 32'h0);
        drive(v); #1; check("rst_seq_accept", v); @(negedge clk);
        v.we = 1; v.waddr = 12'h341; v.wdata = 32'h100;
        drive(v); #1; check("rst_seq_mepc", v); @(negedge clk);
        v.rst = 1; v.we = 0; v.waddr = 12'h0; v.wdata = 32'h0; v.hold = 0;
        drive(v); #1; check("rst_seq_in_reset", v); @(negedge clk);
        v = mk(0, 32'h0, 32'h0, 0, 0, 32'h8, 32'h80, 32'h200, 0, 0, 12'h0, 32'h0, 0, 0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive(v); #1; check($sformatf("rst_seq_after%0d", k), v); @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
